vga_src_sched: RTL and testbench

Frame-synchronous video source scheduler between the VGA timing generator and the RGB565 output pins. It shares the output pixel path between the internal 8-bar test pattern and the camera pixel FIFO. The camera source is handed over only on frame boundaries, and the block aligns the FIFO to camera start-of-frame. On underflow or misalignment it falls back to the test pattern until the next frame.

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_src_sched_if.sv | 22 ++
 rtl/vga_bar_pattern.sv | 27 ++
 rtl/vga_src_sched.sv | 136 +++++++++++++
 tb/tb_vga_src_sched.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: constants and types shared by the VGA output path.
// Holds the scheduler state codes, bar colours, default geometry and the output bundle.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int BAR_W_DEF    = 80;

    localparam logic [1:0] ST_BAR   = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_CAM   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    typedef struct packed {
        logic [15:0] pix;
        logic        de;
        logic        hs;
        logic        vs;
    } vid_out_t;

    function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
        logic [15:0] c;
        unique case (idx)
            3'd0: c = RGB_WHITE;
            3'd1: c = RGB_YELLOW;
            3'd2: c = RGB_CYAN;
            3'd3: c = RGB_GREEN;
            3'd4: c = RGB_MAGENTA;
            3'd5: c = RGB_RED;
            3'd6: c = RGB_BLUE;
            3'd7: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_src_sched_if.sv
// vga_src_sched_if: show-ahead camera FIFO read port.
// master = FIFO side (head word, empty, sof), slave = consumer (pop strobe).
interface vga_src_sched_if;
    logic        iCam_empty;
    logic [15:0] iCam_data;
    logic        iCam_sof;
    logic        oCam_rd;

    modport master (
        output iCam_empty,
        output iCam_data,
        output iCam_sof,
        input  oCam_rd
    );

    modport slave (
        input  iCam_empty,
        input  iCam_data,
        input  iCam_sof,
        output oCam_rd
    );
endinterface

// File: rtl/vga_bar_pattern.sv
// vga_bar_pattern: combinational column -> RGB565 8-bar test pattern.
// Ports: x_i active-pixel column, rgb_o bar colour (index clamped to 7).
module vga_bar_pattern
    import vga_pkg::*;
#(
    parameter int BAR_W = BAR_W_DEF
) (
    input  logic [11:0] x_i,
    output logic [15:0] rgb_o
);

    logic [2:0] idx;

    // Threshold chain instead of a divider; columns past the last
    // bar saturate at index 7.
    always_comb begin
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({20'd0, x_i} >= 32'(k * BAR_W)) begin
                idx = 3'(k);
            end
        end
    end

    assign rgb_o = bar_rgb(idx);

endmodule

// File: rtl/vga_src_sched.sv
// vga_src_sched: frame-synchronous source select between test bars and camera FIFO.
// Ports: iCLK/rst, iSel, timing in (iDE, syncs, iCoord_X), cam FIFO port,
// registered video out (oPix, oDE, oH_SYNC, oV_SYNC), oState, oUnderflow_cnt.
module vga_src_sched
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BAR_W    = BAR_W_DEF
) (
    input  logic        iCLK,
    input  logic        rst,
    input  logic        iSel,
    input  logic        iDE,
    input  logic        iH_SYNC,
    input  logic        iV_SYNC,
    input  logic [11:0] iCoord_X,
    vga_src_sched_if.slave cam,
    output logic [15:0] oPix,
    output logic        oDE,
    output logic        oH_SYNC,
    output logic        oV_SYNC,
    output logic [1:0]  oState,
    output logic [7:0]  oUnderflow_cnt
);

    localparam logic [19:0] PIX_TOTAL = 20'(H_ACTIVE * V_ACTIVE);

    logic [1:0]  state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [7:0]  ucnt_q, ucnt_d;
    logic        vs_prev_q;
    vid_out_t    out_q, out_d;

    logic        fb;
    logic        rd;
    logic        fault;
    logic [15:0] pix;
    logic [15:0] bar;

    vga_bar_pattern #(
        .BAR_W(BAR_W)
    ) u_bar (
        .x_i  (iCoord_X),
        .rgb_o(bar)
    );

    assign fb = vs_prev_q & ~iV_SYNC;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ucnt_d  = ucnt_q;
        rd      = 1'b0;
        fault   = 1'b0;
        pix     = 16'h0000;
        unique case (state_q)
            ST_BAR: begin
                if (iDE) pix = bar;
                if (fb && iSel) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (iDE) pix = bar;
                // Drain everything ahead of the camera start-of-frame.
                rd = ~cam.iCam_empty & ~cam.iCam_sof;
                if (fb) begin
                    if (!iSel) begin
                        state_d = ST_BAR;
                    end else if (!cam.iCam_empty && cam.iCam_sof) begin
                        state_d = ST_CAM;
                        cnt_d   = '0;
                    end
                end
            end
            ST_CAM: begin
                if (iDE && (cnt_q < PIX_TOTAL)) begin
                    if (cam.iCam_empty ||
                        (cam.iCam_sof && (cnt_q != '0))) begin
                        fault = 1'b1;
                    end else begin
                        rd    = 1'b1;
                        pix   = cam.iCam_data;
                        cnt_d = cnt_q + 20'd1;
                    end
                end
                // A boundary overrides a fault in the same cycle.
                if (fb) begin
                    if (iSel) begin
                        cnt_d = '0;
                    end else begin
                        state_d = ST_BAR;
                    end
                end else if (fault) begin
                    state_d = ST_FAULT;
                    if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
                end
            end
            ST_FAULT: begin
                if (iDE) pix = bar;
                if (fb) state_d = iSel ? ST_ARM : ST_BAR;
            end
        endcase
    end

    always_comb begin
        out_d.pix = pix;
        out_d.de  = iDE;
        out_d.hs  = iH_SYNC;
        out_d.vs  = iV_SYNC;
    end

    always_ff @(posedge iCLK or posedge rst) begin
        if (rst) begin
            state_q   <= ST_BAR;
            cnt_q     <= '0;
            ucnt_q    <= '0;
            vs_prev_q <= 1'b1;
            out_q     <= '{pix: 16'h0000, de: 1'b0, hs: 1'b1, vs: 1'b1};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ucnt_q    <= ucnt_d;
            vs_prev_q <= iV_SYNC;
            out_q     <= out_d;
        end
    end

    assign cam.oCam_rd    = rd;
    assign oPix           = out_q.pix;
    assign oDE            = out_q.de;
    assign oH_SYNC        = out_q.hs;
    assign oV_SYNC        = out_q.vs;
    assign oState         = state_q;
    assign oUnderflow_cnt = ucnt_q;

endmodule

// File: tb/tb_vga_src_sched.sv
// tb_vga_src_sched: scoreboard bench for vga_src_sched on a reduced 16x4 raster.
// Drives timing and a queue-backed FIFO; a reference model predicts every output.
module tb_vga_src_sched;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int BW = 2;
    localparam int HT = H + 4;

    localparam logic [1:0] S_BAR = 2'd0;
    localparam logic [1:0] S_ARM = 2'd1;
    localparam logic [1:0] S_CAM = 2'd2;
    localparam logic [1:0] S_FLT = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, de, hs, vs;
    logic [11:0] x;
    logic [15:0] pix;
    logic        ode, ohs, ovs;
    logic [1:0]  st;
    logic [7:0]  ucnt;

    vga_src_sched_if cam_if ();

    vga_src_sched #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .BAR_W   (BW)
    ) dut (
        .iCLK          (clk),
        .rst           (rst),
        .iSel          (sel),
        .iDE           (de),
        .iH_SYNC       (hs),
        .iV_SYNC       (vs),
        .iCoord_X      (x),
        .cam           (cam_if),
        .oPix          (pix),
        .oDE           (ode),
        .oH_SYNC       (ohs),
        .oV_SYNC       (ovs),
        .oState        (st),
        .oUnderflow_cnt(ucnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] fifo[$];
    logic [18:0] exp_q[$];
    logic [1:0]  m_st;
    int          m_cnt;
    int          m_ucnt;
    logic        m_pvs;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bar_ref(input int xc);
        int i;
        i = xc / BW;
        if (i > 7) i = 7;
        case (i)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_reset();
        m_st   = S_BAR;
        m_cnt  = 0;
        m_ucnt = 0;
        m_pvs  = 1'b1;
        exp_q.delete();
    endtask

    task automatic rst_chk();
        check("rst_pix",   32'(pix),  32'h0);
        check("rst_de",    32'(ode),  32'h0);
        check("rst_hs",    32'(ohs),  32'h1);
        check("rst_vs",    32'(ovs),  32'h1);
        check("rst_state", 32'(st),   32'(S_BAR));
        check("rst_ucnt",  32'(ucnt), 32'h0);
        check("rst_rd",    32'(cam_if.oCam_rd), 32'h0);
    endtask

    task automatic push_frame(input int n, input int sof2);
        for (int i = 0; i < n; i++) begin
            fifo.push_back({(i == 0 || i == sof2), 16'($urandom)});
        end
    endtask

    // One pixel clock: drive, predict, check rd, then check registered outputs.
    task automatic step(input logic d, input logic h, input logic v,
                        input int xc);
        logic        fb, emp, sof_v, rd_e, rd_dut, flt;
        logic [15:0] dat_v, p_e;
        logic [1:0]  st_n;
        int          cnt_n, uc_n;
        logic [18:0] e;
        de = d; hs = h; vs = v; x = 12'(xc);
        emp   = (fifo.size() == 0);
        sof_v = emp ? 1'($urandom) : fifo[0][16];
        dat_v = emp ? 16'hDEAD : fifo[0][15:0];
        cam_if.iCam_empty = emp;
        cam_if.iCam_sof   = sof_v;
        cam_if.iCam_data  = dat_v;
        #1;
        fb = m_pvs && !v;
        p_e = 16'h0; rd_e = 1'b0; flt = 1'b0;
        st_n = m_st; cnt_n = m_cnt; uc_n = m_ucnt;
        if (m_st == S_CAM) begin
            if (d && m_cnt < H * V) begin
                if (emp || (sof_v && m_cnt != 0)) flt = 1'b1;
                else begin
                    rd_e = 1'b1; p_e = dat_v; cnt_n = m_cnt + 1;
                end
            end
            if (fb) begin
                if (sel) cnt_n = 0;
                else st_n = S_BAR;
            end else if (flt) begin
                st_n = S_FLT;
                if (m_ucnt < 255) uc_n = m_ucnt + 1;
            end
        end else begin
            if (d) p_e = bar_ref(xc);
            if (m_st == S_ARM) rd_e = !emp && !sof_v;
            if (fb) begin
                if (m_st == S_BAR && sel) st_n = S_ARM;
                if (m_st == S_FLT) st_n = sel ? S_ARM : S_BAR;
                if (m_st == S_ARM) begin
                    if (!sel) st_n = S_BAR;
                    else if (!emp && sof_v) begin
                        st_n = S_CAM; cnt_n = 0;
                    end
                end
            end
        end
        rd_dut = cam_if.oCam_rd;
        check("rd", 32'(rd_dut), 32'(rd_e));
        exp_q.push_back({p_e, d, h, v});
        @(posedge clk);
        #1;
        if (rd_dut && fifo.size() > 0) void'(fifo.pop_front());
        m_st = st_n; m_cnt = cnt_n; m_ucnt = uc_n; m_pvs = v;
        e = exp_q.pop_front();
        check("out", 32'({pix, ode, ohs, ovs}), 32'(e));
        check("state", 32'(st), 32'(m_st));
        check("ucnt", 32'(ucnt), 32'(m_ucnt));
    endtask

    task automatic frame(input int lines, input int off_line);
        for (int l = 0; l < lines + 2; l++) begin
            if (l == off_line) sel = 1'b0;
            for (int p = 0; p < HT; p++) begin
                step(l < lines && p < H, !(p == H + 1 || p == H + 2),
                     l != lines, p);
            end
        end
    endtask

    task automatic mini();
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1'b1, 1);
        step(1'b0, 1'b1, 1'b1, 0);
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0; de = 1'b1; hs = 1'b0; vs = 1'b0; x = 12'd3;
        cam_if.iCam_empty = 1'b0;
        cam_if.iCam_sof   = 1'b0;
        cam_if.iCam_data  = 16'h1234;
        #1;
        rst_chk();
        repeat (2) @(posedge clk);
        #1;
        rst_chk();
        de = 1'b0; hs = 1'b1; vs = 1'b1;
        rst = 1'b0;
        m_reset();

        // Bars, including a column beyond the raster.
        frame(V, -1);
        step(1'b1, 1'b1, 1'b1, 4095);
        step(1'b1, 1'b1, 1'b1, 3);
        step(1'b0, 1'b1, 1'b1, 0);

        // Arm with 3 leading junk words, then one full camera frame.
        sel = 1'b1;
        push_frame(3, -1);
        fifo[0][16] = 1'b0;
        push_frame(H * V, -1);
        frame(V, -1);
        check("discard", 32'(fifo.size()), 32'(H * V));
        check("armed", 32'(st), 32'(S_ARM));
        frame(V, -1);
        check("cam_on", 32'(st), 32'(S_CAM));
        frame(V, -1);
        check("drained", 32'(fifo.size()), 32'h0);

        // Underflow at line 2 pixel 5.
        push_frame(2 * H + 5, -1);
        frame(V, -1);
        check("uf_cnt", 32'(ucnt), 32'd1);
        check("uf_arm", 32'(st), 32'(S_ARM));

        // Stray start-of-frame at pixel 10.
        push_frame(H * V, 10);
        frame(V, -1);
        frame(V, -1);
        check("mis_cnt", 32'(ucnt), 32'd2);
        check("mis_nopop", 32'(fifo.size()), 32'(H * V - 10));

        // Extra active line past the frame, deselect mid-frame.
        for (int i = 0; i < 14; i++) fifo.push_back({1'b0, 16'($urandom)});
        frame(V, -1);
        frame(V + 1, 2);
        check("desel_bar", 32'(st), 32'(S_BAR));
        check("full_nopop", 32'(fifo.size()), 32'd4);

        // Boundary coinciding with an underflow.
        fifo.delete();
        push_frame(1, -1);
        sel = 1'b1;
        frame(V, -1);
        frame(V, -1);
        step(1'b1, 1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1'b0, 1);
        check("fbwin_st", 32'(st), 32'(S_CAM));
        check("fbwin_cnt", 32'(ucnt), 32'd2);
        step(1'b0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 1'b1, 0);

        // Drive the fault counter into saturation.
        for (int i = 0; i < 600; i++) begin
            if (fifo.size() == 0) push_frame(1, -1);
            mini();
        end
        check("sat", 32'(ucnt), 32'd255);

        // Asynchronous reset in the middle of camera output.
        fifo.delete();
        for (int i = 0; i < 20; i++) begin
            fifo.push_back({(i == 0), 16'($urandom) | 16'h0001});
        end
        for (int i = 0; i < 4 && m_st != S_CAM; i++) mini();
        check("pre_rst_cam", 32'(st), 32'(S_CAM));
        step(1'b1, 1'b1, 1'b1, 2);
        #2;
        rst = 1'b1;
        #1;
        rst_chk();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        frame(V, -1);
        sel = 1'b1;
        frame(V, -1);
        check("rearm", 32'(st), 32'(S_ARM));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
